// File: rtl/rv32i_lsu.sv
// rv32i load/store unit: one outstanding op on a single-beat bus.
// Load results return as a one-cycle register-file write pulse.
module rv32i_lsu #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_write_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        busy_o
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, WB, ERR} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;

  logic          req_ready_q, req_ready_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          wb_write_q, wb_write_d;
  logic [4:0]    wb_waddr_q, wb_waddr_d;
  logic [31:0]   wb_wdata_q, wb_wdata_d;
  logic          err_q, err_d;
  logic [1:0]    err_cause_q, err_cause_d;

  logic          legal, misal, timeout;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic [15:0]   sh;
  logic [31:0]   ld_res;

  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (MAX_WAIT > 0) && (cnt_inc == CW'(MAX_WAIT));

  always_comb begin
    if (req_we_i) legal = (req_funct3_i < 3'd3);
    else          legal = (req_funct3_i != 3'b011) &&
                          (req_funct3_i[2:1] != 2'b11);
    misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
            ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = '0;
    if (req_we_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          st_be   = 4'b0001 << req_addr_i[1:0];
          st_data = {4{req_wdata_i[7:0]}};
        end
        2'b01: begin
          st_be   = req_addr_i[1] ? 4'b1100 : 4'b0011;
          st_data = {2{req_wdata_i[15:0]}};
        end
        default: st_data = req_wdata_i;
      endcase
    end
  end

  // Bring the addressed lane down to bit 0 before extension
  always_comb begin
    sh = 16'(mem_rdata_i >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ld_res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_res = {{16{sh[15]}}, sh};
      3'b100:  ld_res = {24'b0, sh[7:0]};
      3'b101:  ld_res = {16'b0, sh};
      default: ld_res = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    req_ready_d = 1'b0;
    mem_valid_d = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    wb_write_d  = 1'b0;
    wb_waddr_d  = '0;
    wb_wdata_d  = '0;
    err_d       = 1'b0;
    err_cause_d = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = req_we_i;
          f3_d        = req_funct3_i;
          off_d       = req_addr_i[1:0];
          rd_d        = req_rd_i;
          cnt_d       = '0;
          if (!legal) begin
            state_d     = ERR;
            err_d       = 1'b1;
            err_cause_d = 2'b10;
          end else if (misal) begin
            state_d     = ERR;
            err_d       = 1'b1;
            err_cause_d = 2'b01;
          end else begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
            mem_we_d    = req_we_i;
            mem_be_d    = st_be;
            mem_addr_d  = {req_addr_i[31:2], 2'b00};
            mem_wdata_d = st_data;
          end
        end
      end
      BUS: begin
        if (mem_ready_i) begin
          if (we_q) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
          end else begin
            state_d    = WB;
            wb_write_d = (rd_q != 5'd0);
            wb_waddr_d = rd_q;
            wb_wdata_d = (rd_q != 5'd0) ? ld_res : 32'd0;
          end
        end else if (timeout) begin
          state_d     = ERR;
          err_d       = 1'b1;
          err_cause_d = 2'b11;
        end else begin
          cnt_d       = cnt_inc;
          mem_valid_d = 1'b1;
          mem_we_d    = mem_we_q;
          mem_be_d    = mem_be_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      WB, ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      req_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_write_q  <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
      err_q       <= 1'b0;
      err_cause_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      req_ready_q <= req_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_write_q  <= wb_write_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_write_o  = wb_write_q;
  assign wb_waddr_o  = wb_waddr_q;
  assign wb_wdata_o  = wb_wdata_q;
  assign err_o       = err_q;
  assign err_cause_o = err_cause_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: directed table, hand-written sequences and
// random ops checked against an arithmetic reference model.
module tb_rv32i_lsu;

  localparam int MW = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        wb_write_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        err_o;
  logic [1:0]  err_cause_o;
  logic        busy_o;

  rv32i_lsu #(.MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .wb_write_o(wb_write_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o),
    .err_o(err_o), .err_cause_o(err_cause_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic [1:0]  cause;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] res;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(
    logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
    logic [4:0] rd, logic [31:0] rdata, int delay, logic [1:0] cause,
    logic [31:0] maddr, logic [3:0] be, logic [31:0] mwdata,
    logic [31:0] res);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.rdata = rdata; v.delay = delay; v.cause = cause;
    v.maddr = maddr; v.be = be; v.mwdata = mwdata; v.res = res;
    return v;
  endfunction

  // Reference model: behaviour computed from access size and byte offset
  function automatic vec_t model(
    logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
    logic [4:0] rd, logic [31:0] rdata, int delay);
    vec_t v;
    bit legal;
    int size, off;
    longint lane, r, span;
    v = mk(we, f3, addr, wdata, rd, rdata, delay, 0, 0, 0, 0, 0);
    if (we) legal = (f3 <= 2);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size = 1 << f3[1:0];
    off  = int'(addr % 4);
    if (!legal)                v.cause = 2'd2;
    else if (addr % size != 0) v.cause = 2'd1;
    else if (delay >= MW)      v.cause = 2'd3;
    v.maddr = addr - off;
    if (we) begin
      v.be = 4'(((1 << size) - 1) << off);
      if (size == 1)      v.mwdata = (wdata % 256) * 32'h0101_0101;
      else if (size == 2) v.mwdata = (wdata % 65536) * 32'h0001_0001;
      else                v.mwdata = wdata;
    end else begin
      v.be = 4'hF;
      v.mwdata = 0;
      if (v.cause == 0) begin
        if (size == 4) v.res = rdata;
        else begin
          span = 64'd1 << (8 * size);
          lane = longint'(rdata) / (64'd1 << (8 * off));
          r = lane % span;
          if (!f3[2] && r >= span / 2) r = r - span;
          v.res = 32'(r);
        end
      end
    end
    return v;
  endfunction

  task automatic run_op(input string t, input vec_t v);
    int k;
    bit rdy;
    k = 0;
    while (req_ready_o !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) chk({t, ".wait_ready"}, {31'b0, req_ready_o}, 1);
    req_valid_i  = 1'b1;
    req_we_i     = v.we;
    req_funct3_i = v.f3;
    req_addr_i   = v.addr;
    req_wdata_i  = v.wdata;
    req_rd_i     = v.rd;
    step();
    req_valid_i  = 1'b0;
    req_we_i     = 1'($urandom);
    req_funct3_i = 3'($urandom);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    req_rd_i     = 5'($urandom);
    if (v.cause == 2'd1 || v.cause == 2'd2) begin
      chk({t, ".err"}, {31'b0, err_o}, 1);
      chk({t, ".cause"}, {30'b0, err_cause_o}, {30'b0, v.cause});
      chk({t, ".no_bus"}, {31'b0, mem_valid_o}, 0);
      chk({t, ".rdy_err"}, {31'b0, req_ready_o}, 0);
      step();
      chk({t, ".rdy_back"}, {31'b0, req_ready_o}, 1);
      chk({t, ".err_1cyc"}, {31'b0, err_o}, 0);
      return;
    end
    for (int c = 0; c < MW; c++) begin
      chk({t, ".valid"}, {31'b0, mem_valid_o}, 1);
      chk({t, ".we"}, {31'b0, mem_we_o}, {31'b0, v.we});
      chk({t, ".addr"}, mem_addr_o, v.maddr);
      chk({t, ".be"}, {28'b0, mem_be_o}, {28'b0, v.be});
      chk({t, ".wdata"}, mem_wdata_o, v.mwdata);
      chk({t, ".bus_quiet"}, {30'b0, wb_write_o, err_o}, 0);
      chk({t, ".bus_busy"}, {30'b0, busy_o, req_ready_o}, 2);
      rdy = (c == v.delay);
      mem_ready_i = rdy;
      mem_rdata_i = rdy ? v.rdata : $urandom;
      step();
      mem_ready_i = 1'b0;
      if (rdy) break;
    end
    chk({t, ".bus_off"}, {31'b0, mem_valid_o}, 0);
    if (v.cause == 2'd3) begin
      chk({t, ".to_err"}, {29'b0, err_o, err_cause_o}, 32'd7);
      chk({t, ".to_nowb"}, {31'b0, wb_write_o}, 0);
      step();
      chk({t, ".to_rdy"}, {31'b0, req_ready_o}, 1);
    end else if (v.we) begin
      chk({t, ".st_done"}, {29'b0, req_ready_o, busy_o, wb_write_o}, 4);
      chk({t, ".st_noerr"}, {31'b0, err_o}, 0);
    end else begin
      chk({t, ".wb"}, {31'b0, wb_write_o}, {31'b0, (v.rd != 0)});
      chk({t, ".waddr"}, {27'b0, wb_waddr_o},
          (v.rd != 0) ? {27'b0, v.rd} : 32'd0);
      chk({t, ".wres"}, wb_wdata_o, (v.rd != 0) ? v.res : 32'd0);
      chk({t, ".wb_rdy"}, {31'b0, req_ready_o}, 0);
      step();
      chk({t, ".wb_done"}, {30'b0, req_ready_o, wb_write_o}, 2);
    end
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;

    tbl.push_back(mk(0, 3'b010, 32'h100, 0, 5, 32'hDEADBEEF, 0,
                     0, 32'h100, 4'hF, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'b000, 32'h203, 0, 6, 32'h80FF1234, 1,
                     0, 32'h200, 4'hF, 0, 32'hFFFFFF80));
    tbl.push_back(mk(0, 3'b100, 32'h203, 0, 7, 32'h80FF1234, 0,
                     0, 32'h200, 4'hF, 0, 32'h00000080));
    tbl.push_back(mk(0, 3'b001, 32'h202, 0, 8, 32'h80FF1234, 2,
                     0, 32'h200, 4'hF, 0, 32'hFFFF80FF));
    tbl.push_back(mk(1, 3'b000, 32'h11, 32'hA5, 9, 0, 0,
                     0, 32'h10, 4'b0010, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(1, 3'b001, 32'h12, 32'h1234, 9, 0, 1,
                     0, 32'h10, 4'b1100, 32'h12341234, 0));
    tbl.push_back(mk(1, 3'b010, 32'h44, 32'h12345678, 1, 0, 2,
                     0, 32'h44, 4'hF, 32'h12345678, 0));
    tbl.push_back(mk(0, 3'b010, 32'h102, 0, 5, 0, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b011, 32'h100, 0, 5, 0, 0,
                     2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b101, 32'h3, 0, 0, 0, 0,
                     2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b101, 32'h201, 0, 3, 0, 0,
                     1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h300, 0, 4, 32'h11111111, 9,
                     3, 32'h300, 4'hF, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h300, 0, 4, 32'h0BADF00D, 3,
                     0, 32'h300, 4'hF, 0, 32'h0BADF00D));
    tbl.push_back(mk(0, 3'b010, 32'h400, 0, 0, 32'hCAFEF00D, 0,
                     0, 32'h400, 4'hF, 0, 32'hCAFEF00D));
    tbl.push_back(mk(1, 3'b000, 32'h7, 32'h1234567F, 2, 0, 3,
                     0, 32'h4, 4'b1000, 32'h7F7F7F7F, 0));

    step();
    step();
    chk("rst.ctrl", {27'b0, req_ready_o, mem_valid_o, wb_write_o,
                     err_o, busy_o}, 0);
    chk("rst.mem", {mem_addr_o[27:0], mem_be_o}, 0);
    chk("rst.wb", {wb_waddr_o, 25'b0, mem_we_o, err_cause_o}, 0);
    chk("rst.wdata", wb_wdata_o | mem_wdata_o, 0);
    rst_ni = 1'b1;
    step();
    chk("rst.release_rdy", {31'b0, req_ready_o}, 1);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    // Reset in BUS with mem_ready high: the op must vanish silently
    run_op("pre_rst", tbl[0]);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h500; req_rd_i = 5'd9;
    step();
    req_valid_i = 1'b0;
    chk("mid.bus", {31'b0, mem_valid_o}, 1);
    rst_ni = 1'b0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    step();
    mem_ready_i = 1'b0;
    chk("mid.rst_bus", {28'b0, mem_valid_o, wb_write_o, err_o, busy_o}, 0);
    chk("mid.rst_rdy", {31'b0, req_ready_o}, 0);
    rst_ni = 1'b1;
    step();
    chk("mid.rel_rdy", {31'b0, req_ready_o}, 1);
    chk("mid.rel_quiet", {29'b0, wb_write_o, err_o, mem_valid_o}, 0);

    for (int i = 0; i < 80; i++) begin
      rv = model(1'($urandom), 3'($urandom_range(0, 7)), $urandom,
                 $urandom, 5'($urandom), $urandom,
                 $urandom_range(0, MW + 1));
      run_op($sformatf("rnd%0d", i), rv);
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
